// File: rtl/branch_target_lut.sv
// branch_target_lut
//   Runtime-programmable branch-target table for the fetch stage.
//   N = 2**A entries, each {mode, value}. Absolute entries (mode 0) return the
//   stored target; relative entries (mode 1) return pc_in + offset mod 2**D.
//   After every reset the table clears itself with a sequential sweep
//   (INIT state, o_busy high), then services writes and lookups (READY).
//
// Handshake: strobes only, no back-pressure. i_wr_en / i_rd_en are accepted on
//   any rising edge where the FSM is READY and i_reset is low; while o_busy is
//   high they are dropped. An accepted lookup produces exactly one
//   o_target_valid pulse on the following cycle, in issue order.
//
// Ports
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_wr_en/addr/data/rel  table write: entry[addr] <= {rel, data}
//   i_rd_en/addr, i_pc_in  lookup request and PC of the branching instruction
//   o_target               registered resolved target (holds between lookups)
//   o_target_valid         one-cycle pulse per accepted lookup
//   o_target_rel           mode of the entry that produced o_target
//   o_busy                 init sweep in progress
//   o_dbg_state            FSM state (0 = INIT, 1 = READY) for observation
module branch_target_lut #(
  parameter int D = 10,
  parameter int A = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_wr_en,
  input  logic [A-1:0] i_wr_addr,
  input  logic [D-1:0] i_wr_data,
  input  logic         i_wr_rel,
  input  logic         i_rd_en,
  input  logic [A-1:0] i_rd_addr,
  input  logic [D-1:0] i_pc_in,
  output logic [D-1:0] o_target,
  output logic         o_target_valid,
  output logic         o_target_rel,
  output logic         o_busy,
  output logic         o_dbg_state
);

  localparam int N = 1 << A;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t         r_state;
  logic [A-1:0]   r_idx;
  logic [D:0]     r_mem [N];
  logic [D-1:0]   r_target;
  logic           r_target_valid;
  logic           r_target_rel;

  logic           w_ready;
  logic           w_hit;
  logic [D:0]     w_entry;
  logic [D-1:0]   w_sum;
  logic [D-1:0]   w_result;
  logic           w_mem_we;
  logic [A-1:0]   w_mem_addr;
  logic [D:0]     w_mem_data;

  assign w_ready = (r_state == ST_READY);

  // Write-first: a same-cycle write to the looked-up entry is forwarded,
  // including its mode, so the relative add uses the new offset.
  assign w_hit   = i_wr_en && (i_wr_addr == i_rd_addr);
  assign w_entry = w_hit ? {i_wr_rel, i_wr_data} : r_mem[i_rd_addr];

  // D-bit add; the carry out is dropped so negative offsets wrap naturally.
  assign w_sum    = i_pc_in + w_entry[D-1:0];
  assign w_result = w_entry[D] ? w_sum : w_entry[D-1:0];

  // Single write port shared by the clearing sweep and the loader path.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = i_wr_addr;
    w_mem_data = {i_wr_rel, i_wr_data};
    if (!i_reset) begin
      if (r_state == ST_INIT) begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_idx;
        w_mem_data = '0;
      end else begin
        w_mem_we   = i_wr_en;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_INIT;
      r_idx          <= '0;
      r_target       <= '0;
      r_target_valid <= 1'b0;
      r_target_rel   <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_target_valid <= 1'b0;
          r_idx          <= r_idx + A'(1);
          if (r_idx == {A{1'b1}}) begin
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          r_target_valid <= i_rd_en;
          if (i_rd_en) begin
            r_target     <= w_result;
            r_target_rel <= w_entry[D];
          end
        end
        default: begin
          r_state        <= ST_INIT;
          r_idx          <= '0;
          r_target_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_target       = r_target;
  assign o_target_valid = r_target_valid;
  assign o_target_rel   = r_target_rel;
  assign o_busy         = !w_ready;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_branch_target_lut.sv
module tb_branch_target_lut;

  localparam int D = 10;
  localparam int A = 4;
  localparam int N = 1 << A;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_data;
  logic         wr_rel;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic [D-1:0] pc_in;
  logic [D-1:0] target;
  logic         target_valid;
  logic         target_rel;
  logic         busy;
  logic         dbg_state;

  always #5 clk = ~clk;

  branch_target_lut #(.D(D), .A(A)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_wr_en        (wr_en),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .i_wr_rel       (wr_rel),
    .i_rd_en        (rd_en),
    .i_rd_addr      (rd_addr),
    .i_pc_in        (pc_in),
    .o_target       (target),
    .o_target_valid (target_valid),
    .o_target_rel   (target_rel),
    .o_busy         (busy),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [D:0] exp_q[$];   // {rel, target}
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [D:0] act, input logic [D:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding lookup.
  always @(negedge clk) begin
    if (target_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got target=0x%0h rel=%0b, expected no result",
                 target, target_rel);
      end else begin
        logic [D:0] e;
        e = exp_q.pop_front();
        if ({target_rel, target} !== e) begin
          miscompares++;
          $display("FAIL lookup: got rel=%0b target=%0d, expected rel=%0b target=%0d",
                   target_rel, target, e[D], e[D-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_rel = 1'b0;
    rd_en = 1'b0; rd_addr = '0; pc_in = '0;
  endtask

  task automatic do_write(input logic [A-1:0] a, input logic [D-1:0] d, input logic rel);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_rel = rel;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_lookup(input logic [A-1:0] a, input logic [D-1:0] pc,
                           input logic erel, input logic [D-1:0] etgt);
    rd_en = 1'b1; rd_addr = a; pc_in = pc;
    exp_q.push_back({erel, etgt});
    step();
    rd_en = 1'b0;
  endtask

  // Release reset and measure how many cycles busy stays high (including the
  // cycle right after release); bounded so a stuck busy cannot hang the run.
  task automatic release_and_wait(input string name, input bit check_len);
    int cycles;
    reset = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      step();
    end
    if (cycles >= 100) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: busy still high after %0d cycles, expected low", name, cycles);
    end else if (check_len) begin
      check({name, "_busy_len"}, (D+1)'(cycles), (D+1)'(N));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) step();

    // Reset values.
    check("reset_target", {1'b0, target}, '0);
    check("reset_valid_rel", {(D-1)'(0), target_valid, target_rel}, '0);
    check("reset_busy", {(D)'(0), busy}, (D+1)'(1));

    // Init sweep length, then every entry reads back absolute 0.
    release_and_wait("init", 1'b1);
    for (int i = 0; i < N; i++) do_lookup(A'(i), D'(i * 37), 1'b0, '0);
    step();

    // Absolute entry, then confirm the pulse is single and target holds.
    do_write(4'd4, 10'd120, 1'b0);
    do_lookup(4'd4, 10'd500, 1'b0, 10'd120);
    step();
    step();
    check("hold_target", {target_rel, target}, {1'b0, 10'd120});
    check("hold_valid_low", {(D)'(0), target_valid}, '0);

    // Relative entry with offset -1, including wrap below zero.
    do_write(4'd9, 10'h3FF, 1'b1);
    do_lookup(4'd9, 10'd4, 1'b1, 10'd3);
    do_lookup(4'd9, 10'd0, 1'b1, 10'd1023);

    // Same-cycle write and lookup of entry 9: new offset -5 is used.
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 10'h3FB; wr_rel = 1'b1;
    do_lookup(4'd9, 10'd20, 1'b1, 10'd15);
    wr_en = 1'b0;

    // Write to a different entry alongside a lookup; both take effect.
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 10'd7; wr_rel = 1'b0;
    do_lookup(4'd4, 10'd0, 1'b0, 10'd120);
    wr_en = 1'b0;
    do_lookup(4'd2, 10'd900, 1'b0, 10'd7);
    // Relative add with carry out discarded: 1000 + 40 = 1040 -> 16.
    do_write(4'd15, 10'd40, 1'b1);
    do_lookup(4'd15, 10'd1000, 1'b1, 10'd16);
    step();

    // Strobes while busy are dropped; programmed entries are cleared.
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 10'd55; wr_rel = 1'b1;
      rd_en = 1'b1; rd_addr = 4'd5; pc_in = 10'd3;
      step();
    end
    idle_inputs();
    release_and_wait("busy_strobes", 1'b0);
    do_lookup(4'd5, 10'd3, 1'b0, '0);
    do_lookup(4'd9, 10'd20, 1'b0, '0);
    do_lookup(4'd4, 10'd1, 1'b0, '0);
    step();

    // Reset on the edge that samples a lookup: the result never appears.
    do_write(4'd4, 10'd120, 1'b0);
    rd_en = 1'b1; rd_addr = 4'd4; pc_in = 10'd0;
    reset = 1'b1;
    step();
    rd_en = 1'b0;
    check("reset_drop_valid", {(D)'(0), target_valid}, '0);
    check("reset_drop_target", {1'b0, target}, '0);
    step();
    release_and_wait("reinit", 1'b1);
    do_lookup(4'd4, 10'd0, 1'b0, '0);
    repeat (3) step();

    check("queue_drained", (D+1)'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
